// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the control unit / datapath and the pipeline
// sequencing controller. The master side is the control unit and datapath.
// The slave side is pipe_ctrl.
interface pipe_ctrl_if;
  logic [1:0] branch_EX;
  logic       jump_EX;
  logic       zero_EX;
  logic [1:0] muldiv_EX;
  logic       hilo_read_EX;
  logic [4:0] rs_EX;
  logic [4:0] rt_EX;
  logic       uses_rt_EX;
  logic       regwrite_WB;
  logic [4:0] writeaddr_WB;

  logic [1:0] pc_src_EX;
  logic       flush_EX;
  logic       stall_FETCH;
  logic       valid_EX;
  logic       enhilo_EX;
  logic       hilo_busy;
  logic       fwd_a_EX;
  logic       fwd_b_EX;

  modport master (
    output branch_EX, jump_EX, zero_EX, muldiv_EX, hilo_read_EX,
           rs_EX, rt_EX, uses_rt_EX, regwrite_WB, writeaddr_WB,
    input  pc_src_EX, flush_EX, stall_FETCH, valid_EX, enhilo_EX,
           hilo_busy, fwd_a_EX, fwd_b_EX
  );

  modport slave (
    input  branch_EX, jump_EX, zero_EX, muldiv_EX, hilo_read_EX,
           rs_EX, rt_EX, uses_rt_EX, regwrite_WB, writeaddr_WB,
    output pc_src_EX, flush_EX, stall_FETCH, valid_EX, enhilo_EX,
           hilo_busy, fwd_a_EX, fwd_b_EX
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the FETCH / EX / WB MIPS pipeline.
// The block resolves branches and jumps into PC-select and flush commands.
// It schedules the multi-cycle multiply/divide unit and stalls fetch on
// hi/lo hazards. It also produces the WB-to-EX forwarding selects.
// MDU timing: the issue cycle counts as the first MDU cycle. The counter is
// loaded with N-1 at issue, and the last busy cycle is the one where it
// reads 1. As a result, enhilo_EX fires in cycle issue+N-1. N=1 completes
// in the issue cycle itself, so no busy window is opened.
module pipe_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MDU      = 2'd2
  } state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] mdu_cnt;
  logic [5:0] cnt_next;
  logic       busy_q;
  logic       busy_next;
  logic       valid_q;

  logic       is_mul;
  logic       is_div;
  logic       ex_live;
  logic       hazard;
  logic       jmp;
  logic       br_taken;
  logic       redirect;
  logic       issue;
  logic [5:0] issue_load;
  logic       mdu_last;

  // Decode the EX instruction and resolve stall > redirect > normal priority;
  // the wrong-path instruction sitting in EX during REDIRECT is ignored
  always_comb begin
    is_mul     = (bus.muldiv_EX == 2'b01);
    is_div     = (bus.muldiv_EX == 2'b10);
    ex_live    = valid_q && (state != REDIRECT);
    hazard     = busy_q && ex_live && (bus.hilo_read_EX || is_mul || is_div);
    jmp        = ex_live && !hazard && bus.jump_EX;
    br_taken   = ex_live && !hazard &&
                 (((bus.branch_EX == 2'b01) && bus.zero_EX) ||
                  ((bus.branch_EX == 2'b10) && !bus.zero_EX));
    redirect   = jmp || br_taken;
    issue      = ex_live && !hazard && !busy_q && (is_mul || is_div);
    issue_load = is_div ? DIV_LOAD : MULT_LOAD;
    mdu_last   = busy_q && (mdu_cnt == 6'd1);
  end

  // Next MDU counter/busy and next sequencing state
  always_comb begin
    busy_next = busy_q;
    cnt_next  = mdu_cnt;
    if (issue && (issue_load != 6'd0)) begin
      busy_next = 1'b1;
      cnt_next  = issue_load;
    end else if (mdu_last) begin
      busy_next = 1'b0;
      cnt_next  = 6'd0;
    end else if (busy_q) begin
      cnt_next  = mdu_cnt - 6'd1;
    end

    if (redirect)
      state_next = REDIRECT;
    else if (busy_next)
      state_next = MDU;
    else
      state_next = RUN;
  end

  // Drive the EX-cycle commands toward the PC mux, EX register and WB gate
  always_comb begin
    if (jmp)
      bus.pc_src_EX = 2'b10;
    else if (br_taken)
      bus.pc_src_EX = 2'b01;
    else
      bus.pc_src_EX = 2'b00;
    bus.flush_EX    = (state == REDIRECT);
    bus.stall_FETCH = hazard;
    bus.valid_EX    = ex_live && !hazard;
    bus.enhilo_EX   = mdu_last || (issue && (issue_load == 6'd0));
    bus.hilo_busy   = busy_q;
    bus.fwd_a_EX    = bus.regwrite_WB && (bus.writeaddr_WB == bus.rs_EX) &&
                      (bus.rs_EX != 5'd0);
    bus.fwd_b_EX    = bus.regwrite_WB && (bus.writeaddr_WB == bus.rt_EX) &&
                      (bus.rt_EX != 5'd0) && bus.uses_rt_EX;
  end

  // Sequencing state, MDU counter and EX-valid register; reset aborts any MDU op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      mdu_cnt <= 6'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      mdu_cnt <= cnt_next;
      busy_q  <= busy_next;
      valid_q <= (state != REDIRECT);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with default MULT_CYCLES=4, DIV_CYCLES=32.
// Inputs change 1ns after each rising edge. Outputs are sampled on the
// falling edge.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipe_ctrl_if bus();

  pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.branch_EX    = 2'b00;
    bus.jump_EX      = 1'b0;
    bus.zero_EX      = 1'b0;
    bus.muldiv_EX    = 2'b00;
    bus.hilo_read_EX = 1'b0;
    bus.rs_EX        = 5'd0;
    bus.rt_EX        = 5'd0;
    bus.uses_rt_EX   = 1'b0;
    bus.regwrite_WB  = 1'b0;
    bus.writeaddr_WB = 5'd0;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {bus.pc_src_EX, bus.flush_EX, bus.stall_FETCH, bus.valid_EX,
              bus.enhilo_EX, bus.hilo_busy, bus.fwd_a_EX, bus.fwd_b_EX};
      total++;
      if (outs !== 9'd0) begin
        bad++;
        $display("[TB] FAIL reset_outputs cyc%0d: got %b want 000000000", i, outs);
      end
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.valid_EX !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_valid1: got %b want 0", bus.valid_EX);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.valid_EX !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_valid2: got %b want 1", bus.valid_EX);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    bus.regwrite_WB = 1'b1; bus.writeaddr_WB = 5'd5;
    bus.rs_EX = 5'd5; bus.rt_EX = 5'd5; bus.uses_rt_EX = 1'b0;
    #1;
    total++;
    if ({bus.fwd_a_EX, bus.fwd_b_EX} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL fwd_r5: got %b want 10", {bus.fwd_a_EX, bus.fwd_b_EX});
    end
    bus.writeaddr_WB = 5'd0; bus.rs_EX = 5'd0; bus.rt_EX = 5'd0; bus.uses_rt_EX = 1'b1;
    #1;
    total++;
    if ({bus.fwd_a_EX, bus.fwd_b_EX} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL fwd_r0: got %b want 00", {bus.fwd_a_EX, bus.fwd_b_EX});
    end
    bus.writeaddr_WB = 5'd7; bus.rs_EX = 5'd3; bus.rt_EX = 5'd7;
    #1;
    total++;
    if ({bus.fwd_a_EX, bus.fwd_b_EX} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL fwd_rt7: got %b want 01", {bus.fwd_a_EX, bus.fwd_b_EX});
    end
    bus.regwrite_WB = 1'b0; bus.rs_EX = 5'd7;
    #1;
    total++;
    if ({bus.fwd_a_EX, bus.fwd_b_EX} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL fwd_nowrite: got %b want 00", {bus.fwd_a_EX, bus.fwd_b_EX});
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_branch();
    // beq taken
    bus.branch_EX = 2'b01; bus.zero_EX = 1'b1;
    @(negedge clk);
    total++;
    if (bus.pc_src_EX !== 2'b01) begin
      bad++;
      $display("[TB] FAIL beq_taken_pc_src: got %b want 01", bus.pc_src_EX);
    end
    next_cycle();
    // Wrong-path beq still on the inputs must be ignored during REDIRECT.
    @(negedge clk);
    total++;
    if ({bus.flush_EX, bus.pc_src_EX} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL beq_redirect flush/pc: got %b want 100", {bus.flush_EX, bus.pc_src_EX});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.valid_EX, bus.flush_EX} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL beq_bubble valid/flush: got %b want 00", {bus.valid_EX, bus.flush_EX});
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (bus.valid_EX !== 1'b1) begin
      bad++;
      $display("[TB] FAIL beq_recover_valid: got %b want 1", bus.valid_EX);
    end
    next_cycle();
    // beq not taken
    bus.branch_EX = 2'b01; bus.zero_EX = 1'b0;
    @(negedge clk);
    total++;
    if (bus.pc_src_EX !== 2'b00) begin
      bad++;
      $display("[TB] FAIL beq_not_taken_pc_src: got %b want 00", bus.pc_src_EX);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.flush_EX, bus.valid_EX} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL beq_not_taken flush/valid: got %b want 01", {bus.flush_EX, bus.valid_EX});
    end
    next_cycle();
    // bne taken on zero=0
    bus.branch_EX = 2'b10; bus.zero_EX = 1'b0;
    @(negedge clk);
    total++;
    if (bus.pc_src_EX !== 2'b01) begin
      bad++;
      $display("[TB] FAIL bne_taken_pc_src: got %b want 01", bus.pc_src_EX);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.flush_EX !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bne_flush: got %b want 1", bus.flush_EX);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_mult_stall();
    // cycle t: mult issue
    bus.muldiv_EX = 2'b01;
    @(negedge clk);
    total++;
    if ({bus.stall_FETCH, bus.hilo_busy, bus.enhilo_EX} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL mult_issue stall/busy/enhilo: got %b want 000",
               {bus.stall_FETCH, bus.hilo_busy, bus.enhilo_EX});
    end
    next_cycle();
    // t+1..t+3: dependent mfhi carrying a taken beq stays stalled
    bus.muldiv_EX = 2'b00; bus.hilo_read_EX = 1'b1;
    bus.branch_EX = 2'b01; bus.zero_EX = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus.stall_FETCH, bus.valid_EX, bus.pc_src_EX, bus.hilo_busy, bus.enhilo_EX} !==
          {1'b1, 1'b0, 2'b00, 1'b1, (k == 3)}) begin
        bad++;
        $display("[TB] FAIL mult_stall t+%0d stall/valid/pc/busy/enhilo: got %b want 1000 1 %0d", k,
                 {bus.stall_FETCH, bus.valid_EX, bus.pc_src_EX, bus.hilo_busy, bus.enhilo_EX}, (k == 3));
      end
      next_cycle();
    end
    // t+4: released, mfhi valid and its branch now resolves
    @(negedge clk);
    total++;
    if ({bus.stall_FETCH, bus.valid_EX, bus.hilo_busy, bus.enhilo_EX, bus.pc_src_EX} !== 6'b010001) begin
      bad++;
      $display("[TB] FAIL mult_release stall/valid/busy/enhilo/pc: got %b want 010001",
               {bus.stall_FETCH, bus.valid_EX, bus.hilo_busy, bus.enhilo_EX, bus.pc_src_EX});
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_jump_div_busy();
    int enh_count;
    int enh_at;
    int flush_count;
    enh_count = 0;
    enh_at = -1;
    flush_count = 0;
    bus.muldiv_EX = 2'b10;
    @(negedge clk);
    total++;
    if ({bus.hilo_busy, bus.enhilo_EX} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL div_issue busy/enhilo: got %b want 00", {bus.hilo_busy, bus.enhilo_EX});
    end
    next_cycle();
    for (int k = 1; k <= 34; k++) begin
      idle_inputs();
      if (k == 3) bus.jump_EX = 1'b1;
      @(negedge clk);
      if (bus.enhilo_EX === 1'b1) begin
        enh_count++;
        enh_at = k;
      end
      if (bus.flush_EX === 1'b1) flush_count++;
      if (k == 3) begin
        total++;
        if ({bus.pc_src_EX, bus.hilo_busy} !== 3'b101) begin
          bad++;
          $display("[TB] FAIL jump_busy pc/busy: got %b want 101", {bus.pc_src_EX, bus.hilo_busy});
        end
      end
      if (k == 4) begin
        total++;
        if ({bus.flush_EX, bus.hilo_busy} !== 2'b11) begin
          bad++;
          $display("[TB] FAIL jump_redirect flush/busy: got %b want 11", {bus.flush_EX, bus.hilo_busy});
        end
      end
      if (k == 5) begin
        total++;
        if ({bus.valid_EX, bus.hilo_busy} !== 2'b01) begin
          bad++;
          $display("[TB] FAIL jump_bubble valid/busy: got %b want 01", {bus.valid_EX, bus.hilo_busy});
        end
      end
      if (k == 32) begin
        total++;
        if (bus.hilo_busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL div_done_busy: got %b want 0", bus.hilo_busy);
        end
      end
      next_cycle();
    end
    total++;
    if (enh_count !== 1 || enh_at !== 31) begin
      bad++;
      $display("[TB] FAIL div_enhilo count/cycle: got %0d at %0d want 1 at 31", enh_count, enh_at);
    end
    total++;
    if (flush_count !== 1) begin
      bad++;
      $display("[TB] FAIL jump_flush_count: got %0d want 1", flush_count);
    end
  endtask

  task automatic test_div_reset();
    int enh_count;
    int busy_count;
    enh_count = 0;
    busy_count = 0;
    bus.muldiv_EX = 2'b10;
    next_cycle();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({bus.hilo_busy, bus.enhilo_EX} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL div_busy d+%0d busy/enhilo: got %b want 10", k, {bus.hilo_busy, bus.enhilo_EX});
      end
      next_cycle();
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus.hilo_busy, bus.enhilo_EX} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL div_abort busy/enhilo: got %b want 00", {bus.hilo_busy, bus.enhilo_EX});
    end
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.enhilo_EX === 1'b1) enh_count++;
      if (bus.hilo_busy === 1'b1) busy_count++;
      next_cycle();
    end
    total++;
    if (enh_count !== 0 || busy_count !== 0) begin
      bad++;
      $display("[TB] FAIL div_abort_after enhilo/busy cycles: got %0d/%0d want 0/0", enh_count, busy_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.jump_EX = 1'b1;
    @(negedge clk);
    total++;
    if (bus.pc_src_EX !== 2'b10) begin
      bad++;
      $display("[TB] FAIL run_jump_pc_src: got %b want 10", bus.pc_src_EX);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    bus.branch_EX = 2'b11; bus.zero_EX = 1'b1; bus.muldiv_EX = 2'b11;
    @(negedge clk);
    total++;
    if (bus.pc_src_EX !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reserved_branch_pc_src: got %b want 00", bus.pc_src_EX);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.flush_EX, bus.hilo_busy, bus.valid_EX} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL reserved_ops flush/busy/valid: got %b want 001",
               {bus.flush_EX, bus.hilo_busy, bus.valid_EX});
    end
    next_cycle();
  endtask

  // Run every scenario in order and report
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_forward();
    test_branch();
    test_mult_stall();
    test_jump_div_busy();
    test_div_reset();
    next_cycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
